// File: rtl/signature_analyzer.sv
// signature_analyzer
// Compresses a run of NUM_SAMPLES input bytes into a SIG_W-bit signature
// with a multiple-input signature register (MISR). A run starts on a one-cycle
// start request, accepts one sample per in_valid cycle, and ends in DONE with
// the signature frozen for the grading logic to compare.
// Optional build macro: SIG_SAMPLE_CNT_EN exposes the accepted-sample counter
// as output port sample_count.

module signature_analyzer #(
  parameter int              SIG_W       = 16,
  parameter int              DATA_W      = 8,
  parameter int              NUM_SAMPLES = 256,
  parameter logic [SIG_W-1:0] POLY       = 16'h1021,
  parameter logic [SIG_W-1:0] SEED       = 16'h0000,
  localparam int             CNT_W       = $clog2(NUM_SAMPLES + 1)
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] data_in,
  output logic              busy,
  output logic              done,
`ifdef SIG_SAMPLE_CNT_EN
  output logic [CNT_W-1:0]  sample_count,
`endif
  output logic [SIG_W-1:0]  signature
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // The run ends on the edge that accepts this count value plus one.
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_SAMPLES - 1);

  state_t            r_state;
  logic [SIG_W-1:0]  r_sig;
  logic [CNT_W-1:0]  r_sampleCount;

  state_t            w_stateNext;
  logic [SIG_W-1:0]  w_sigNext;
  logic [CNT_W-1:0]  w_countNext;
  logic [SIG_W-1:0]  w_shifted;
  logic [SIG_W-1:0]  w_misr;

  // MISR step: shift left, fold the outgoing MSB back through the tap mask,
  // then mix in the zero-extended sample. Pure XOR/shift, no carries.
  always_comb begin
    w_shifted = {r_sig[SIG_W-2:0], 1'b0};
    if (r_sig[SIG_W-1]) begin
      w_shifted = w_shifted ^ POLY;
    end
    w_misr = w_shifted ^ SIG_W'(data_in);
  end

  // Next-state and datapath selection; a start cycle reseeds but never samples.
  always_comb begin
    w_stateNext = r_state;
    w_sigNext   = r_sig;
    w_countNext = r_sampleCount;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_stateNext = RUN;
          w_sigNext   = SEED;
          w_countNext = '0;
        end
      end
      RUN: begin
        if (in_valid) begin
          w_sigNext   = w_misr;
          w_countNext = r_sampleCount + CNT_W'(1);
          if (r_sampleCount == LAST_IDX) begin
            w_stateNext = DONE;
          end
        end
      end
      DONE: begin
        if (start) begin
          w_stateNext = RUN;
          w_sigNext   = SEED;
          w_countNext = '0;
        end
      end
      default: begin
        w_stateNext = IDLE;
        w_sigNext   = SEED;
        w_countNext = '0;
      end
    endcase
  end

  // State, signature and counter registers; clear overrides everything.
  always_ff @(posedge clk) begin
    if (clear) begin
      r_state       <= IDLE;
      r_sig         <= SEED;
      r_sampleCount <= '0;
    end else begin
      r_state       <= w_stateNext;
      r_sig         <= w_sigNext;
      r_sampleCount <= w_countNext;
    end
  end

  assign busy      = (r_state == RUN);
  assign done      = (r_state == DONE);
  assign signature = r_sig;

`ifdef SIG_SAMPLE_CNT_EN
  assign sample_count = r_sampleCount;
`endif

endmodule

// File: tb/tb_signature_analyzer.sv
// Testbench for signature_analyzer: two instances (NUM_SAMPLES=2 and 17) share
// one set of inputs; each vector names which instance it checks.
// Expected results are queued when a vector is driven and compared one clock
// later. Build with SIG_SAMPLE_CNT_EN defined to also check sample_count.

module tb_signature_analyzer;

  logic       clk;
  logic       clear;
  logic       start;
  logic       in_valid;
  logic [7:0] data_in;

  logic        busy2, done2;
  logic [15:0] sig2;
  logic        busy17, done17;
  logic [15:0] sig17;
`ifdef SIG_SAMPLE_CNT_EN
  logic [1:0]  cnt2;
  logic [4:0]  cnt17;
`endif

  int checks;
  int passes;

  typedef struct {
    logic        clr;
    logic        st;
    logic        iv;
    logic [7:0]  d;
    int          tgt;
    logic [15:0] sig;
    logic        busy;
    logic        done;
    int          cnt;
    string       name;
  } vec_t;

  typedef struct {
    int          tgt;
    logic [15:0] sig;
    logic        busy;
    logic        done;
    int          cnt;
    string       name;
  } exp_t;

  vec_t vecs[$];
  exp_t sbQ[$];

  signature_analyzer #(.NUM_SAMPLES(2)) dut2 (
    .clk(clk), .clear(clear), .start(start), .in_valid(in_valid),
    .data_in(data_in), .busy(busy2), .done(done2),
`ifdef SIG_SAMPLE_CNT_EN
    .sample_count(cnt2),
`endif
    .signature(sig2)
  );

  signature_analyzer #(.NUM_SAMPLES(17)) dut17 (
    .clk(clk), .clear(clear), .start(start), .in_valid(in_valid),
    .data_in(data_in), .busy(busy17), .done(done17),
`ifdef SIG_SAMPLE_CNT_EN
    .sample_count(cnt17),
`endif
    .signature(sig17)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic addVec(input logic clr, input logic st, input logic iv,
                        input logic [7:0] d, input int tgt, input logic [15:0] sig,
                        input logic b, input logic dn, input int cnt, input string name);
    vec_t v;
    v.clr = clr; v.st = st; v.iv = iv; v.d = d; v.tgt = tgt;
    v.sig = sig; v.busy = b; v.done = dn; v.cnt = cnt; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic checkOutput();
    exp_t e;
    logic [15:0] aSig;
    logic aBusy, aDone;
    int aCnt;
    checks++;
    if (sbQ.size() == 0) begin
      $display("[TB] FAIL scoreboard: empty queue, actual size 0 required >0");
      return;
    end
    e = sbQ.pop_front();
    aCnt = e.cnt;
    if (e.tgt == 0) begin
      aSig = sig2; aBusy = busy2; aDone = done2;
`ifdef SIG_SAMPLE_CNT_EN
      aCnt = int'(cnt2);
`endif
    end else begin
      aSig = sig17; aBusy = busy17; aDone = done17;
`ifdef SIG_SAMPLE_CNT_EN
      aCnt = int'(cnt17);
`endif
    end
    if (aSig === e.sig && aBusy === e.busy && aDone === e.done && aCnt == e.cnt) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: actual sig=%h busy=%b done=%b cnt=%0d, required sig=%h busy=%b done=%b cnt=%0d",
               e.name, aSig, aBusy, aDone, aCnt, e.sig, e.busy, e.done, e.cnt);
    end
  endtask

  // Called at a falling edge: drive, queue the expectation, compare next fall.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    clear = v.clr; start = v.st; in_valid = v.iv; data_in = v.d;
    e.tgt = v.tgt; e.sig = v.sig; e.busy = v.busy; e.done = v.done;
    e.cnt = v.cnt; e.name = v.name;
    sbQ.push_back(e);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic step(input logic clr, input logic st, input logic iv,
                      input logic [7:0] d, input int tgt, input logic [15:0] sig,
                      input logic b, input logic dn, input int cnt, input string name);
    vec_t v;
    v.clr = clr; v.st = st; v.iv = iv; v.d = d; v.tgt = tgt;
    v.sig = sig; v.busy = b; v.done = dn; v.cnt = cnt; v.name = name;
    applyStimulus(v);
  endtask

  initial begin
    logic [15:0] model;
    checks = 0;
    passes = 0;
    clear = 1'b0; start = 1'b0; in_valid = 1'b0; data_in = 8'h00;

    // Table: NUM_SAMPLES=2 instance unless tgt=1.
    addVec(1, 1, 1, 8'hFF, 0, 16'h0000, 0, 0, 0, "reset1");
    addVec(1, 1, 1, 8'hFF, 1, 16'h0000, 0, 0, 0, "reset2_n17");
    addVec(0, 0, 1, 8'hFF, 0, 16'h0000, 0, 0, 0, "idle_after_reset");
    addVec(0, 1, 1, 8'h01, 0, 16'h0000, 1, 0, 0, "start_no_sample");
    addVec(0, 0, 1, 8'h01, 0, 16'h0001, 1, 0, 1, "basic_s1");
    addVec(0, 0, 1, 8'h01, 0, 16'h0003, 0, 1, 2, "basic_s2_done");
    addVec(0, 0, 1, 8'h55, 0, 16'h0003, 0, 1, 2, "done_no_sample");
    addVec(0, 1, 1, 8'h01, 0, 16'h0000, 1, 0, 0, "restart_from_done");
    addVec(0, 0, 1, 8'h01, 0, 16'h0001, 1, 0, 1, "gap_s1");
    addVec(0, 1, 0, 8'h01, 0, 16'h0001, 1, 0, 1, "gap_start_ignored");
    addVec(0, 0, 0, 8'h01, 0, 16'h0001, 1, 0, 1, "gap_hold");
    addVec(0, 0, 1, 8'h01, 0, 16'h0003, 0, 1, 2, "gap_s2_done");
    addVec(0, 1, 0, 8'h00, 0, 16'h0000, 1, 0, 0, "midrun_start");
    addVec(0, 0, 1, 8'h01, 0, 16'h0001, 1, 0, 1, "midrun_s1");
    addVec(1, 0, 1, 8'h01, 0, 16'h0000, 0, 0, 0, "midrun_clear");
    addVec(0, 0, 1, 8'h01, 0, 16'h0000, 0, 0, 0, "idle_ignores_data");
    addVec(0, 1, 0, 8'h00, 0, 16'h0000, 1, 0, 0, "fresh_start");
    addVec(0, 0, 1, 8'h01, 0, 16'h0001, 1, 0, 1, "fresh_s1");
    addVec(0, 0, 1, 8'h01, 0, 16'h0003, 0, 1, 2, "fresh_s2_done");

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
    end

    // Done value holds for ten more cycles with noise on the data inputs.
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 1, 8'($urandom_range(0, 255)), 0, 16'h0003, 0, 1, 2, "done_hold");
    end

    // Clear while in DONE returns to idle with the seed.
    step(1, 0, 0, 8'h00, 0, 16'h0000, 0, 0, 0, "clear_in_done");

    // Feedback path on the 17-sample instance: 0x01 then sixteen 0x00.
    step(1, 0, 0, 8'h00, 1, 16'h0000, 0, 0, 0, "n17_clear");
    step(0, 1, 0, 8'h00, 1, 16'h0000, 1, 0, 0, "n17_start");
    model = 16'h0001;
    step(0, 0, 1, 8'h01, 1, model, 1, 0, 1, "n17_s1");
    for (int k = 2; k <= 16; k++) begin
      model = model << 1;
      step(0, 0, 1, 8'h00, 1, model, 1, 0, k, "n17_shift");
    end
    if (model != 16'h8000) begin
      $display("[TB] FAIL n17_model: actual %h required 8000", model);
    end
    step(0, 0, 1, 8'h00, 1, 16'h1021, 0, 1, 17, "n17_feedback_done");
    step(0, 0, 1, 8'hAA, 1, 16'h1021, 0, 1, 17, "n17_hold");
    step(0, 1, 1, 8'hAA, 1, 16'h0000, 1, 0, 0, "n17_restart");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/signature_analyzer.md
Name: signature_analyzer

Overview:
- Downstream consumer of the student circuit's 8-bit cct_output.
- Compresses a run of NUM_SAMPLES output bytes into a 16-bit signature using a multiple-input signature register (MISR).
- The signature is compared against a golden value (e.g. 16'H622D) by the bench or by grading logic.
- Sits between the circuit under test and the result display/checker.

Parameters:
- SIG_W, 16, signature width in bits.
- DATA_W, 8, input data width; must be <= SIG_W.
- NUM_SAMPLES, 256, number of accepted samples per run; range 1..65535.
- POLY, 16'H1021, MISR feedback polynomial (tap mask).
- SEED, 16'H0000, signature value at reset and at each start.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- clear  input  1  synchronous active-high reset.
- start  input  1  one-cycle request to begin a run.
- in_valid  input  1  data_in is a sample this cycle.
- data_in  input  DATA_W  sample byte (the student circuit's cct_output).
- busy  output  1  high while in RUN.
- done  output  1  high in DONE; signature is final.
- signature  output  SIG_W  current MISR contents (registered).

Behaviour:
- Reset: clock and reset are single clk, synchronous active-high clear. Clear has highest priority over every other input and acts on the next rising edge. After clear: state=IDLE, signature=SEED, count=0, busy=0, done=0.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 -> RUN; signature loads SEED, count=0. The start cycle itself never samples, even if in_valid=1.
  - RUN: in_valid=1 accepts one sample.
    - Update: shifted = {sig[SIG_W-2:0],1'b0}; if sig[SIG_W-1]=1, shifted ^= POLY; sig_next = shifted ^ zero-extended data_in.
    - count increments on each accepted sample.
    - in_valid=0 holds signature and count.
    - start is ignored in RUN.
  - RUN -> DONE: on the edge that accepts sample number NUM_SAMPLES. done=1 and busy=0 are visible the cycle after the last accepted sample. No further samples are taken.
  - DONE: signature and done held indefinitely. start=1 -> RUN with signature=SEED, count=0, done=0 on the next edge.
- Outputs: busy=1 exactly in RUN; done=1 exactly in DONE.
- Widths: count is $clog2(NUM_SAMPLES+1) bits and never wraps (the run ends first). All arithmetic is XOR/shift; no carries.
- Simultaneous clear and start: clear wins, state=IDLE.
- Clear mid-run: run is discarded, signature=SEED, no done pulse.

Optional Feature:
- Macro SIG_SAMPLE_CNT_EN.
- When defined: adds output port sample_count (width $clog2(NUM_SAMPLES+1)), which is the registered count. It reads 0 after clear or start, increments per accepted sample, and holds NUM_SAMPLES in DONE.
- When undefined: the port is absent and the counter is internal only. Signature, busy and done behaviour are identical in both builds.

Test Plan:
- Reset: assert clear 2 cycles with start=1, in_valid=1, data_in=8'HFF -> signature=16'H0000, busy=0, done=0 throughout and after.
- Basic run, NUM_SAMPLES=2: start, then samples 8'H01, 8'H01 on consecutive cycles -> signature 16'H0001 then 16'H0003; done=1 and busy=0 the following cycle; value holds for 10 more cycles.
- Feedback path, NUM_SAMPLES=17: sample 8'H01 followed by sixteen 8'H00 -> signature 16'H8000 after sample 16, then 16'H1021 at done.
- Gaps and ignored start, NUM_SAMPLES=2: in_valid toggling 1,0,0,1 with data 8'H01 each, start pulsed mid-run -> final signature 16'H0003; done asserts only after the 2nd accepted sample.
- Clear mid-run: after 1 accepted sample, pulse clear -> IDLE with signature=16'H0000 and no done. A fresh start and the basic-run stimulus reproduces 16'H0003.
- Restart from DONE: start in DONE -> done=0, busy=1, signature=SEED next cycle. With SIG_SAMPLE_CNT_EN: sample_count goes 0,1,2 and holds 2 in DONE.
